// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of the CPU, DMA and memory-side signals of the data-memory arbiter.
// slave modport is the arbiter's view; master is the view of the requesters plus memory.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_done;
    logic [DATA_W-1:0] dma_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [31:0]       stall_cnt;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_stall, dma_gnt, dma_done, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, stall_cnt
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_stall, dma_gnt, dma_done, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall_cnt
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU MEM stage and a DMA/loader port.
// Ports: clk_i (rising edge), rst_n_i (async, active low), bus (dmem_arbiter_if.slave):
//   cpu_* request/stall/load data, dma_* request/grant/done/load data,
//   mem_* memory port, stall_cnt saturating count of stalled cycles.
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input logic          clk_i,
    input logic          rst_n_i,
    dmem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;
    localparam int LW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(STARVE_MAX + 2);
    localparam logic [LW-1:0] LAT_LOAD = LW'(MEM_LAT - 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic [1:0]        state;
    logic              owner;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [LW-1:0]     lat;
    logic [SW-1:0]     starve;
    logic [DATA_W-1:0] cpu_rdata;
    logic [DATA_W-1:0] dma_rdata;
    logic [31:0]       stall_cnt;
    logic              dma_win;
    logic              stall;

    // owner: 0 = CPU, 1 = DMA
    assign dma_win = bus.dma_req & (~bus.cpu_req | (starve >= SMAX));
    // gated by reset so every output reads 0 while reset is held
    assign stall   = rst_n_i & bus.cpu_req & ~(state == DONE & ~owner);

    assign bus.cpu_stall = stall;
    assign bus.cpu_rdata = cpu_rdata;
    assign bus.dma_rdata = dma_rdata;
    assign bus.dma_gnt   = owner & (state == ACCESS | state == DONE);
    assign bus.dma_done  = owner & (state == DONE);
    assign bus.mem_en    = state == ACCESS;
    // the write strobe fires only in the last access cycle
    assign bus.mem_we    = (state == ACCESS) & we_q & (lat == '0);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.stall_cnt = stall_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            owner     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            lat       <= '0;
            starve    <= '0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + {31'd0, stall & ~&stall_cnt};
            if (state == IDLE) begin
                if (bus.cpu_req | bus.dma_req) begin
                    owner   <= dma_win;
                    we_q    <= dma_win ? bus.dma_we : bus.cpu_we;
                    addr_q  <= dma_win ? bus.dma_addr : bus.cpu_addr;
                    wdata_q <= dma_win ? bus.dma_wdata : bus.cpu_wdata;
                    lat     <= LAT_LOAD;
                    starve  <= dma_win ? '0 : starve + SW'(bus.dma_req);
                    state   <= ACCESS;
                end
            end else if (state == ACCESS) begin
                if (lat == '0) begin
                    state <= DONE;
                    if (!we_q && !owner) cpu_rdata <= bus.mem_rdata;
                    if (!we_q && owner) dma_rdata <= bus.mem_rdata;
                end else begin
                    lat <= lat - 1'b1;
                end
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a scoreboard of expected read data and grant order.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int tests = 0;
    int fails = 0;
    int writes_a = 0;
    logic [31:0] exp_q[$];
    logic gnt_q[$];
    logic [31:0] mem_a[64];
    logic [31:0] mem_b[64];

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .bus(a));
    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .bus(b));

    assign a.mem_rdata = mem_a[a.mem_addr[7:2]];
    assign b.mem_rdata = mem_b[b.mem_addr[7:2]];

    always @(posedge clk) begin
        if (a.mem_en && a.mem_we) begin
            mem_a[a.mem_addr[7:2]] = a.mem_wdata;
            writes_a++;
        end
        if (b.mem_en && b.mem_we) mem_b[b.mem_addr[7:2]] = b.mem_wdata;
    end

    task automatic cpu_go(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int stalls, output int we_at, output int we_n);
        @(negedge clk);
        a.cpu_we = we;
        a.cpu_addr = addr;
        a.cpu_wdata = wdata;
        a.cpu_req = 1'b1;
        stalls = 0;
        we_at = -1;
        we_n = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (a.mem_we) begin
                we_at = c;
                we_n++;
            end
            if (!a.cpu_stall) break;
            stalls++;
            @(negedge clk);
        end
        a.cpu_req = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        tests++;
        if ({a.cpu_stall, a.dma_gnt, a.dma_done, a.mem_en, a.mem_we} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl got %b want 00000", {a.cpu_stall, a.dma_gnt, a.dma_done, a.mem_en, a.mem_we});
        end
        tests++;
        if ({a.stall_cnt, a.cpu_rdata, a.dma_rdata, a.mem_addr, a.mem_wdata} !== 160'd0) begin
            fails++;
            $display("FAIL reset_data got cnt=%0h cr=%0h dr=%0h want all 0", a.stall_cnt, a.cpu_rdata, a.dma_rdata);
        end
        tests++;
        if ({b.cpu_stall, b.mem_en, b.stall_cnt} !== 34'd0) begin
            fails++;
            $display("FAIL reset_b got %b/%b/%0h want 0", b.cpu_stall, b.mem_en, b.stall_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_access;
        int st, wa, wn;
        logic [31:0] e;
        mem_a[0] = 32'd5;
        exp_q.push_back(32'd5);
        cpu_go(1'b0, 32'h0, 32'h0, st, wa, wn);
        tests++;
        if (st !== 3) begin
            fails++;
            $display("FAIL rst_pre_stall got %0d want 3", st);
        end
        e = exp_q.pop_front();
        tests++;
        if (a.cpu_rdata !== e) begin
            fails++;
            $display("FAIL rst_pre_rdata got %0h want %0h", a.cpu_rdata, e);
        end
        @(negedge clk);
        a.cpu_req = 1'b1;
        @(negedge clk);
        #1;
        tests++;
        if (a.mem_en !== 1'b1) begin
            fails++;
            $display("FAIL rst_in_access got mem_en=%b want 1", a.mem_en);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({a.cpu_stall, a.dma_gnt, a.dma_done, a.mem_en, a.mem_we, a.stall_cnt, a.cpu_rdata} !== 69'd0) begin
            fails++;
            $display("FAIL rst_async got stall=%b en=%b we=%b cnt=%0h cr=%0h want all 0",
                     a.cpu_stall, a.mem_en, a.mem_we, a.stall_cnt, a.cpu_rdata);
        end
        a.cpu_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tests++;
        if (writes_a !== 0) begin
            fails++;
            $display("FAIL rst_no_write got %0d writes want 0", writes_a);
        end
    endtask

    task automatic test_store_load;
        int st, wa, wn;
        logic [31:0] e;
        cpu_go(1'b1, 32'h4, 32'h2A, st, wa, wn);
        tests++;
        if (st !== 3 || wn !== 1 || wa !== 2) begin
            fails++;
            $display("FAIL store_we got stalls=%0d we_n=%0d we_at=%0d want 3/1/2", st, wn, wa);
        end
        exp_q.push_back(32'h2A);
        cpu_go(1'b0, 32'h4, 32'h0, st, wa, wn);
        tests++;
        if (st !== 3 || wn !== 0) begin
            fails++;
            $display("FAIL load_stall got stalls=%0d we_n=%0d want 3/0", st, wn);
        end
        e = exp_q.pop_front();
        tests++;
        if (a.cpu_rdata !== e) begin
            fails++;
            $display("FAIL load_rdata got %0h want %0h", a.cpu_rdata, e);
        end
        @(negedge clk);
        tests++;
        if (a.stall_cnt !== 32'd6) begin
            fails++;
            $display("FAIL stall_cnt got %0d want 6", a.stall_cnt);
        end
    endtask

    task automatic test_dma_only;
        int gn = 0, dn = 0, done_at = -1, sth = 0;
        logic [31:0] e;
        logic seen = 1'b0;
        @(negedge clk);
        a.dma_we = 1'b1;
        a.dma_addr = 32'h8;
        a.dma_wdata = 32'h11;
        a.dma_req = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (a.dma_gnt) gn++;
            if (a.cpu_stall) sth++;
            if (a.dma_done) begin
                dn++;
                done_at = c;
                a.dma_req = 1'b0;
            end
            @(negedge clk);
        end
        tests++;
        if (gn !== 3) begin
            fails++;
            $display("FAIL dma_gnt got %0d cycles want 3", gn);
        end
        tests++;
        if (dn !== 1 || done_at !== 3) begin
            fails++;
            $display("FAIL dma_done got n=%0d at=%0d want 1/3", dn, done_at);
        end
        tests++;
        if (sth !== 0 || mem_a[2] !== 32'h11) begin
            fails++;
            $display("FAIL dma_write got stall=%0d mem=%0h want 0/11", sth, mem_a[2]);
        end
        exp_q.push_back(32'h11);
        a.dma_we = 1'b0;
        a.dma_req = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (a.dma_done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        a.dma_req = 1'b0;
        e = exp_q.pop_front();
        tests++;
        if (!seen || a.dma_rdata !== e) begin
            fails++;
            $display("FAIL dma_rdata got done=%b data=%0h want 1/%0h", seen, a.dma_rdata, e);
        end
    endtask

    task automatic test_back_to_back;
        int got = 0, last = -1;
        logic g, e;
        gnt_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        @(negedge clk);
        a.cpu_we = 1'b0;
        a.cpu_addr = 32'h10;
        a.dma_we = 1'b0;
        a.dma_addr = 32'h14;
        a.cpu_req = 1'b1;
        a.dma_req = 1'b1;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (a.dma_done || (a.cpu_req && !a.cpu_stall)) begin
                g = a.dma_done;
                e = gnt_q.pop_front();
                tests++;
                if (g !== e) begin
                    fails++;
                    $display("FAIL grant_order #%0d got dma=%b want dma=%b", got, g, e);
                end
                if (g) begin
                    tests++;
                    if (dut_a.starve !== '0) begin
                        fails++;
                        $display("FAIL starve_clear got %0d want 0", dut_a.starve);
                    end
                end
                got++;
                last = c;
                if (got == 6) break;
            end
            @(negedge clk);
        end
        a.cpu_req = 1'b0;
        a.dma_req = 1'b0;
        tests++;
        if (got !== 6 || last !== 23) begin
            fails++;
            $display("FAIL b2b_throughput got n=%0d last=%0d want 6/23", got, last);
        end
    endtask

    task automatic test_mem_lat1;
        int st = 0, en = 0, wa = -1, wn = 0;
        logic [31:0] e;
        mem_b[0] = 32'h77;
        exp_q.push_back(32'h77);
        @(negedge clk);
        b.cpu_we = 1'b0;
        b.cpu_addr = 32'h0;
        b.cpu_req = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (b.mem_en) en++;
            if (!b.cpu_stall) break;
            st++;
            @(negedge clk);
        end
        b.cpu_req = 1'b0;
        tests++;
        if (st !== 2 || en !== 1) begin
            fails++;
            $display("FAIL lat1_load got stalls=%0d en=%0d want 2/1", st, en);
        end
        e = exp_q.pop_front();
        tests++;
        if (b.cpu_rdata !== e) begin
            fails++;
            $display("FAIL lat1_rdata got %0h want %0h", b.cpu_rdata, e);
        end
        @(negedge clk);
        b.cpu_we = 1'b1;
        b.cpu_addr = 32'h4;
        b.cpu_wdata = 32'h99;
        b.cpu_req = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (b.mem_we) begin
                wa = c;
                wn++;
            end
            if (!b.cpu_stall) break;
            @(negedge clk);
        end
        b.cpu_req = 1'b0;
        tests++;
        if (wn !== 1 || wa !== 1 || mem_b[1] !== 32'h99) begin
            fails++;
            $display("FAIL lat1_store got we_n=%0d we_at=%0d mem=%0h want 1/1/99", wn, wa, mem_b[1]);
        end
    endtask

    task automatic test_saturation;
        int st, wa, wn;
        @(negedge clk);
        force dut_a.stall_cnt = 32'hFFFF_FFFE;
        release dut_a.stall_cnt;
        #1;
        tests++;
        if (a.stall_cnt !== 32'hFFFF_FFFE) begin
            fails++;
            $display("FAIL sat_preset got %0h want fffffffe", a.stall_cnt);
        end
        cpu_go(1'b0, 32'h10, 32'h0, st, wa, wn);
        @(negedge clk);
        tests++;
        if (st !== 3 || a.stall_cnt !== 32'hFFFF_FFFF) begin
            fails++;
            $display("FAIL sat_hold got stalls=%0d cnt=%0h want 3/ffffffff", st, a.stall_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        {a.cpu_req, a.cpu_we, a.dma_req, a.dma_we} = 4'b0;
        {a.cpu_addr, a.cpu_wdata, a.dma_addr, a.dma_wdata} = 128'd0;
        {b.cpu_req, b.cpu_we, b.dma_req, b.dma_we} = 4'b0;
        {b.cpu_addr, b.cpu_wdata, b.dma_addr, b.dma_wdata} = 128'd0;
        #1 rst_n = 1'b0;
        test_reset();
        test_reset_mid_access();
        test_store_load();
        test_dma_only();
        test_back_to_back();
        test_mem_lat1();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d tests", tests);
        $fatal(1, "watchdog");
    end
endmodule
